// File: rtl/i2s_tx_serializer_pkg.sv
// i2s_tx_serializer_pkg: shared FSM state and data-alignment mode encodings
package i2s_tx_serializer_pkg;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
    localparam int MODE_I2S = 0;
    localparam int MODE_LJ = 1;
endpackage

// File: rtl/i2s_tx_serializer_if.sv
// i2s_tx_serializer_if: sample handshake, run control and serial audio lines
interface i2s_tx_serializer_if #(parameter int SAMPLE_W = 16);
    logic                enable;
    logic                in_valid;
    logic                in_ready;
    logic [SAMPLE_W-1:0] in_left;
    logic [SAMPLE_W-1:0] in_right;
    logic                bclk;
    logic                ws;
    logic                sd;
    logic                frame_start;
    logic                underrun;
    modport master (
        output enable, in_valid, in_left, in_right,
        input  in_ready, bclk, ws, sd, frame_start, underrun
    );
    modport slave (
        input  enable, in_valid, in_left, in_right,
        output in_ready, bclk, ws, sd, frame_start, underrun
    );
endinterface

// File: rtl/i2s_tx_serializer_bclk_gen.sv
// bclk_gen: divides clk into bclk and strobes the clk on which bclk falls
module bclk_gen #(
    parameter int BCLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic bclk,
    output logic tick
);
    localparam int CW = $clog2(BCLK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(BCLK_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(BCLK_DIV / 2);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          bclk_q, bclk_d;

    always_comb begin
        tick = run && cnt_q == CNT_MAX;
        cnt_d = (!run || tick) ? '0 : cnt_q + 1'b1;
        bclk_d = cnt_d >= CNT_HALF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            bclk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            bclk_q <= bclk_d;
        end
    end

    assign bclk = bclk_q;
endmodule

// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer: one-entry stereo buffer feeding an I2S / left-justified
// serial transmitter with frame-aligned start and stop.
module i2s_tx_serializer
    import i2s_tx_serializer_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int SLOT_W   = 16,
    parameter int BCLK_DIV = 4,
    parameter int MODE     = MODE_I2S
) (
    input logic clk,
    input logic rst,
    i2s_tx_serializer_if.slave io
);
    localparam int FW = 2 * SLOT_W;
    localparam int BW = $clog2(FW);
    localparam logic [BW-1:0] BIT_LAST = BW'(FW - 1);
    localparam logic [BW-1:0] BIT_RIGHT = BW'(SLOT_W);

    if (BCLK_DIV < 2 || BCLK_DIV % 2 != 0 || SLOT_W < SAMPLE_W) begin : g_param_check
        $error("i2s_tx_serializer: BCLK_DIV must be even and >= 2, SLOT_W >= SAMPLE_W");
    end

    state_t              state_q, state_d;
    logic                active_q, active_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [FW-1:0]       sh_q, sh_d;
    logic                dly_q, dly_d;
    logic                full_q, full_d;
    logic [SAMPLE_W-1:0] left_q, left_d;
    logic [SAMPLE_W-1:0] right_q, right_d;
    logic                fs_q, fs_d;
    logic                ur_q, ur_d;
    logic                ws_q, ws_d;
    logic                sd_q, sd_d;
    logic                tick, accept, frame_end, load;

    bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk_gen (
        .clk  (clk),
        .rst  (rst),
        .run  (active_q),
        .bclk (io.bclk),
        .tick (tick)
    );

    // active_q is low on the first RUN clk, which forces the initial frame load.
    always_comb begin
        accept = io.in_valid && !full_q;
        frame_end = tick && bit_q == BIT_LAST;
        load = state_q == RUN && (!active_q || (frame_end && io.enable));
        state_d = state_q;
        active_d = active_q;
        bit_d = bit_q;
        sh_d = sh_q;
        dly_d = dly_q;
        full_d = accept ? 1'b1 : load ? 1'b0 : full_q;
        left_d = accept ? io.in_left : left_q;
        right_d = accept ? io.in_right : right_q;
        if (state_q == IDLE) begin
            state_d = io.enable ? RUN : IDLE;
        end else if (frame_end && !io.enable) begin
            state_d = IDLE;
            active_d = 1'b0;
            bit_d = '0;
            sh_d = '0;
            dly_d = 1'b0;
        end else if (load) begin
            active_d = 1'b1;
            bit_d = '0;
            sh_d = full_q ? (FW'(left_q) << (FW - SAMPLE_W)) | (FW'(right_q) << (SLOT_W - SAMPLE_W)) : '0;
            dly_d = sh_q[FW-1];
        end else if (tick) begin
            bit_d = bit_q + 1'b1;
            sh_d = sh_q << 1;
            dly_d = sh_q[FW-1];
        end
        fs_d = load;
        ur_d = load && !full_q;
        ws_d = active_d && bit_d >= BIT_RIGHT;
        sd_d = active_d && (MODE == MODE_LJ ? sh_d[FW-1] : dly_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            active_q <= 1'b0;
            bit_q <= '0;
            sh_q <= '0;
            dly_q <= 1'b0;
            full_q <= 1'b0;
            left_q <= '0;
            right_q <= '0;
            fs_q <= 1'b0;
            ur_q <= 1'b0;
            ws_q <= 1'b0;
            sd_q <= 1'b0;
        end else begin
            state_q <= state_d;
            active_q <= active_d;
            bit_q <= bit_d;
            sh_q <= sh_d;
            dly_q <= dly_d;
            full_q <= full_d;
            left_q <= left_d;
            right_q <= right_d;
            fs_q <= fs_d;
            ur_q <= ur_d;
            ws_q <= ws_d;
            sd_q <= sd_d;
        end
    end

    assign io.in_ready = !full_q;
    assign io.frame_start = fs_q;
    assign io.underrun = ur_q;
    assign io.ws = ws_q;
    assign io.sd = sd_q;
endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb_i2s_tx_serializer: directed checks of left-justified, Philips and padded-slot
// transmitters covering buffering, underrun, frame-aligned stop and async reset.
module tb_i2s_tx_serializer;
    import i2s_tx_serializer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_pass = 0;
    logic [31:0] capa, wsa, capb;
    logic [47:0] capc, wsc;
    logic [3:0]  bpat;
    logic        hi;
    int          urs;

    always #5 clk = ~clk;

    i2s_tx_serializer_if #(.SAMPLE_W(16)) ia ();
    i2s_tx_serializer_if #(.SAMPLE_W(16)) ib ();
    i2s_tx_serializer_if #(.SAMPLE_W(16)) ic ();

    i2s_tx_serializer #(.MODE(MODE_LJ)) dut_lj (.clk(clk), .rst(rst), .io(ia));
    i2s_tx_serializer #(.MODE(MODE_I2S)) dut_i2s (.clk(clk), .rst(rst), .io(ib));
    i2s_tx_serializer #(.SLOT_W(24), .MODE(MODE_LJ)) dut_pad (.clk(clk), .rst(rst), .io(ic));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic wait_start(input string tag, input int sel, input int lat);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sel == 0 ? ia.frame_start : ic.frame_start) && n < 400);
        check(tag, 64'(n), 64'(lat));
    endtask

    initial begin
        ia.enable = 0; ia.in_valid = 0; ia.in_left = '0; ia.in_right = '0;
        ib.enable = 0; ib.in_valid = 0; ib.in_left = '0; ib.in_right = '0;
        ic.enable = 0; ic.in_valid = 0; ic.in_left = '0; ic.in_right = '0;
        repeat (2) @(negedge clk);
        check("reset_a", 64'({ia.in_ready, ia.bclk, ia.ws, ia.sd, ia.frame_start, ia.underrun}), 64'(6'b100000));
        check("reset_c", 64'({ic.in_ready, ic.bclk, ic.ws, ic.sd, ic.frame_start, ic.underrun}), 64'(6'b100000));
        rst = 0;
        ia.in_valid = 1; ia.in_left = 16'hA5F0; ia.in_right = 16'h0F0F;
        ib.in_valid = 1; ib.in_left = 16'hA5F0; ib.in_right = 16'h0F0F;
        ic.in_valid = 1; ic.in_left = 16'h8001; ic.in_right = 16'h1234;
        @(negedge clk);
        check("ready_full", 64'({ia.in_ready, ib.in_ready, ic.in_ready}), 64'(3'b000));
        ia.in_left = 16'hFFFF; ia.in_right = 16'hFFFF;
        ib.in_left = 16'hFFFF; ib.in_right = 16'hFFFF;
        ic.in_valid = 0;
        repeat (2) @(negedge clk);
        ia.in_valid = 0; ib.in_valid = 0;
        ia.enable = 1; ib.enable = 1;
        wait_start("start_lat_a", 0, 2);
        check("first_flags", 64'({ia.frame_start, ia.underrun, ia.in_ready}), 64'(3'b101));
        for (int k = 0; k < 32; k++) begin
            capa[31-k] = ia.sd;
            wsa[31-k] = ia.ws;
            capb[31-k] = ib.sd;
            for (int j = 0; j < 4; j++) begin
                if (k == 0) bpat[3-j] = ia.bclk;
                @(negedge clk);
            end
        end
        check("lj_data", 64'(capa), 64'(32'hA5F00F0F));
        check("lj_ws", 64'(wsa), 64'(32'h0000FFFF));
        check("i2s_data", 64'(capb), 64'(32'h52F80787));
        check("bclk_period", 64'(bpat), 64'(4'b0011));
        check("frame2_underrun", 64'({ia.frame_start, ia.underrun}), 64'(2'b11));
        check("i2s_r_lsb_next", 64'({ib.sd, ia.sd}), 64'(2'b10));
        repeat (12) @(negedge clk);
        ia.enable = 0; ib.enable = 0;
        repeat (112) @(negedge clk);
        check("bit31_ws", 64'({ia.ws, ib.ws}), 64'(2'b11));
        repeat (4) @(negedge clk);
        check("idle_outputs", 64'({ia.frame_start, ia.bclk, ia.ws, ia.sd, ib.bclk, ib.ws, ib.sd}), 64'(0));
        hi = 0;
        repeat (20) begin
            @(negedge clk);
            hi = hi | ia.bclk | ia.ws | ia.frame_start | ib.bclk | ib.frame_start;
        end
        check("idle_quiet", 64'(hi), 64'(0));
        ic.enable = 1;
        wait_start("start_lat_c", 1, 2);
        for (int k = 0; k < 48; k++) begin
            capc[47-k] = ic.sd;
            wsc[47-k] = ic.ws;
            repeat (4) @(negedge clk);
        end
        check("pad_data", 64'(capc), 64'(48'h8001_0012_3400));
        check("pad_ws", 64'(wsc), 64'(48'h0000_00FF_FFFF));
        check("pad_frame48", 64'({ic.frame_start, ic.underrun}), 64'(2'b11));
        urs = 0;
        hi = 0;
        repeat (192) begin
            @(negedge clk);
            urs += int'(ic.underrun);
            hi = hi | ic.sd;
        end
        check("underrun_once", 64'(urs), 64'(1));
        check("zero_frame_sd", 64'(hi), 64'(0));
        check("zero_frame_next", 64'({ic.frame_start, ic.underrun}), 64'(2'b11));
        ic.enable = 0;
        ia.enable = 1;
        wait_start("restart_a", 0, 2);
        ia.in_valid = 1; ia.in_left = 16'h1111; ia.in_right = 16'h2222;
        @(negedge clk);
        ia.in_valid = 0;
        check("refill_full", 64'(ia.in_ready), 64'(0));
        repeat (85) @(negedge clk);
        check("pre_rst", 64'({ia.bclk, ia.ws}), 64'(2'b11));
        rst = 1;
        #1;
        check("rst_async", 64'({ia.in_ready, ia.bclk, ia.ws, ia.sd, ia.frame_start, ia.underrun}), 64'(6'b100000));
        repeat (2) @(negedge clk);
        rst = 0;
        wait_start("post_rst_lat", 0, 2);
        check("post_rst_underrun", 64'({ia.frame_start, ia.underrun}), 64'(2'b11));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/i2s_tx_serializer.md
I2S_TX_SERIALIZER -- requirements
Module: i2s_tx_serializer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  SAMPLE_W, 16, bits per audio sample per channel
  SLOT_W, 16, bit clocks per channel slot; SLOT_W >= SAMPLE_W
  BCLK_DIV, 4, clk cycles per bclk period; even, >= 2
  MODE, 0, 0 = Philips I2S (one-bit data delay after ws edge); 1 = left-justified (no delay)
REQ-002 Ports SHALL be (name, direction, width, meaning):
  clk  input  1  sole clock; all logic on rising edge
  rst  input  1  asynchronous, active-high reset
  enable  input  1  run request; sampled every clk
  in_valid  input  1  stereo sample present
  in_ready  output  1  holding buffer can accept
  in_left  input  SAMPLE_W  left sample, two's complement
  in_right  input  SAMPLE_W  right sample, two's complement
  bclk  output  1  serial bit clock
  ws  output  1  word select; 0 = left slot, 1 = right slot
  sd  output  1  serial data, MSB first
  frame_start  output  1  one-clk pulse at each frame load
  underrun  output  1  one-clk pulse when a frame loads with an empty buffer

Function
REQ-003 Divider counter SHALL count 0..BCLK_DIV-1 and wrap; bclk = 0 for counts 0..BCLK_DIV/2-1, 1 otherwise.
REQ-004 A bit boundary SHALL be the clk on which the divider wraps to 0 (bclk falling edge); ws and sd SHALL change only at bit boundaries.
REQ-005 Bit counter SHALL count 0..2*SLOT_W-1 per frame, advance once per bit boundary, and wrap to 0.
REQ-006 ws SHALL be 0 for bit counts 0..SLOT_W-1 and 1 for SLOT_W..2*SLOT_W-1.
REQ-007 Each slot SHALL carry sample MSB first, then SLOT_W-SAMPLE_W zero pad bits.
REQ-008 MODE=0: sd SHALL lag the MODE=1 bit stream by exactly one bit period; the final right-channel bit SHALL appear in bit 0 of the next frame.
REQ-009 Holding buffer SHALL be one stereo entry; handshake completes on a clk with in_valid & in_ready; in_ready SHALL equal !buffer_full (registered).
REQ-010 Frame load SHALL occur at the bit boundary entering bit count 0: buffer moved into shift register, buffer emptied, frame_start pulsed.
REQ-011 Load with empty buffer SHALL transmit an all-zero frame and pulse underrun on the same clk as frame_start.
REQ-012 Handshake on the load clk SHALL NOT be accepted (in_ready still 0); acceptance resumes the following clk.
REQ-013 in_left/in_right SHALL be ignored when in_valid is 0; samples are never dropped or overwritten while buffer full.
REQ-014 States SHALL be IDLE and RUN; IDLE->RUN when enable=1, first frame load on the next clk.
REQ-015 RUN->IDLE SHALL occur only at frame end (bit count 2*SLOT_W-1 completing) when enable=0; a partial frame is never truncated. MODE=0 trailing delayed bit is dropped.
REQ-016 In IDLE: bclk=0, ws=0, sd=0, counters held at 0, buffer retained and still accepting input.

Reset
REQ-017 rst asserted SHALL immediately force: state IDLE, counters 0, buffer empty, shift/delay registers 0, bclk=0, ws=0, sd=0, frame_start=0, underrun=0, in_ready=1.
REQ-018 rst mid-frame SHALL discard the frame and buffered sample; operation restarts per REQ-014 after release.

Structure
REQ-019 Shared package SHALL hold the state enum (IDLE, RUN) and MODE encodings (MODE_I2S=0, MODE_LJ=1).
REQ-020 Divider SHALL be a sub-module bclk_gen (outputs bclk and bit-boundary strobe); the rest stays in i2s_tx_serializer.
REQ-021 Elaboration SHALL fail for odd BCLK_DIV, BCLK_DIV<2, or SLOT_W<SAMPLE_W.

Verification
REQ-022 Defaults, MODE=1, L=16'hA5F0, R=16'h0F0F -> ws low 16 bits carrying A5F0 MSB first, high 16 bits carrying 0F0F; bclk period 4 clk.
REQ-023 Same data, MODE=0 -> sd identical stream delayed one bit; R LSB (1) in bit 0 of next frame.
REQ-024 SAMPLE_W=16, SLOT_W=24, L=16'h8001 -> slot bits 1000_0000_0000_0001 then 8 zeros; frame = 48 bclk.
REQ-025 enable=1, no in_valid -> zero frame, underrun and frame_start pulse together once per frame.
REQ-026 enable dropped at left-slot bit 3 -> frame completes, IDLE after bit 31, bclk/ws/sd all 0.
REQ-027 rst pulsed at right-slot bit 5 with buffer full -> all outputs 0 same clk, in_ready=1, next frame underruns unless refilled.
